// File: rtl/id_ex_pipe_stage.sv
// Elastic ID/EX pipeline register with a main/skid register pair, a
// synchronous flush that leaves a bubble, and a saturating bubble counter.
module id_ex_pipe_stage #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 11,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stat_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic [DATA_W-1:0]  op_a_in,
  input  logic [DATA_W-1:0]  op_b_in,
  input  logic [DATA_W-1:0]  imm_in,
  input  logic [RADDR_W-1:0] rt_in,
  input  logic [RADDR_W-1:0] rd_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [DATA_W-1:0]  pc_out,
  output logic [DATA_W-1:0]  op_a_out,
  output logic [DATA_W-1:0]  op_b_out,
  output logic [DATA_W-1:0]  imm_out,
  output logic [RADDR_W-1:0] rt_out,
  output logic [RADDR_W-1:0] rd_out,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int ENT_W = CTRL_W + 4 * DATA_W + 2 * RADDR_W;

  logic             m_valid_r, s_valid_r, in_ready_r;
  logic [ENT_W-1:0] m_ent_r, s_ent_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  logic             m_valid_s, s_valid_s;
  logic [ENT_W-1:0] m_ent_s, s_ent_s, in_ent_s;
  logic             accept_s, consume_s;

  assign in_ent_s  = {ctrl_in, pc_in, op_a_in, op_b_in, imm_in, rt_in, rd_in};
  assign accept_s  = in_valid & in_ready_r;
  assign consume_s = m_valid_r & out_ready;

  // Next-state selection for the main and skid registers.
  always_comb begin
    m_valid_s = m_valid_r;
    m_ent_s   = m_ent_r;
    s_valid_s = s_valid_r;
    s_ent_s   = s_ent_r;
    if (flush) begin
      m_valid_s = 1'b0;
      s_valid_s = 1'b0;
    end else if (!m_valid_r || consume_s) begin
      if (s_valid_r) begin
        m_valid_s = 1'b1;
        m_ent_s   = s_ent_r;
        s_valid_s = 1'b0;
      end else if (accept_s) begin
        m_valid_s = 1'b1;
        m_ent_s   = in_ent_s;
      end else begin
        m_valid_s = 1'b0;
      end
    end else if (accept_s) begin
      s_valid_s = 1'b1;
      s_ent_s   = in_ent_s;
    end else begin
      s_valid_s = s_valid_r;
    end
    // An empty main register always carries an all-zero control bundle (NOP).
    if (!m_valid_s) begin
      m_ent_s[ENT_W-1 -: CTRL_W] = {CTRL_W{1'b0}};
    end else begin
      m_ent_s[ENT_W-1 -: CTRL_W] = m_ent_s[ENT_W-1 -: CTRL_W];
    end
  end

  // Pipeline storage and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_r  <= 1'b0;
      s_valid_r  <= 1'b0;
      m_ent_r    <= {ENT_W{1'b0}};
      s_ent_r    <= {ENT_W{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      m_valid_r  <= m_valid_s;
      s_valid_r  <= s_valid_s;
      m_ent_r    <= m_ent_s;
      s_ent_r    <= s_ent_s;
      in_ready_r <= !s_valid_s;
    end
  end

  // Saturating count of cycles presenting a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (stat_clr) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (!m_valid_r && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = m_valid_r;
  assign bubble_cnt = bubble_cnt_r;
  assign {ctrl_out, pc_out, op_a_out, op_b_out, imm_out, rt_out, rd_out} = m_ent_r;

endmodule
